// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image controller: loads an IMG_W x IMG_H frame serially, then streams
// a WIN x WIN fit (sub-sampled) or zoomed window, optionally mirrored horizontally.
module lcd_ctrl_param #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 9,
  parameter int WIN    = 4,
  parameter int FIT_X0 = 1,
  parameter int FIT_SX = 3,
  parameter int FIT_Y0 = 1,
  parameter int FIT_SY = 2,
  parameter int CX0    = 6,
  parameter int CY0    = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] datain,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  output logic [DATA_W-1:0] dataout,
  output logic              output_valid,
  output logic              busy,
  output logic              zoom_mode,
  output logic [1:0]        dbg_state
);
  localparam int N    = IMG_W * IMG_H;
  localparam int AW   = $clog2(N);
  localparam int MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW   = $clog2(MAXD + 1);
  localparam int IW   = $clog2(WIN);
  localparam int HALF = WIN / 2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

  state_t            r_state, w_next;
  logic [2:0]        r_cmd;
  logic [AW-1:0]     r_cnt;
  logic [IW-1:0]     r_i, r_j;
  logic [CW-1:0]     r_cx, r_cy;
  logic              r_zoom, r_mirror, r_valid;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_mem [N];

  logic              w_accept, w_load_last, w_beat_last;
  int                w_ip, w_x, w_y;
  logic [AW-1:0]     w_addr;

  // Handshake: a command is taken on a rising edge where cmd_valid=1 and busy=0 in IDLE;
  // busy stays high until the cycle after the last output beat, and cmd_valid is ignored meanwhile.
  assign busy         = (r_state != S_IDLE) || r_valid;
  assign w_accept     = (r_state == S_IDLE) && cmd_valid && !busy;
  assign w_load_last  = (r_cnt == AW'(N - 1));
  assign w_beat_last  = (r_i == IW'(WIN - 1)) && (r_j == IW'(WIN - 1));
  assign dataout      = r_dout;
  assign output_valid = r_valid;
  assign zoom_mode    = r_zoom;
  assign dbg_state    = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (cmd == 3'd0) ? S_LOAD : S_CALC;
      S_LOAD: if (w_load_last) w_next = S_OUT;
      S_CALC: w_next = S_OUT;
      S_OUT:  if (w_beat_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Frame address of the current output beat; mirroring reverses the column index only.
  always_comb begin
    w_ip = r_mirror ? (WIN - 1 - int'(r_i)) : int'(r_i);
    if (r_zoom) begin
      w_x = int'(r_cx) - HALF + w_ip;
      w_y = int'(r_cy) - HALF + int'(r_j);
    end else begin
      w_x = FIT_X0 + w_ip * FIT_SX;
      w_y = FIT_Y0 + int'(r_j) * FIT_SY;
    end
    w_addr = AW'(w_y * IMG_W + w_x);
  end

  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) r_mem[r_cnt] <= datain;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cmd    <= 3'd0;
      r_cnt    <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_cx     <= CW'(CX0);
      r_cy     <= CW'(CY0);
      r_zoom   <= 1'b0;
      r_mirror <= 1'b0;
      r_valid  <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= (r_state == S_OUT);
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cmd <= cmd;
          r_cnt <= '0;
          r_i   <= '0;
          r_j   <= '0;
        end
        S_LOAD: begin
          r_cnt <= r_cnt + AW'(1);
          if (w_load_last) begin
            r_zoom   <= 1'b0;
            r_mirror <= 1'b0;
          end
        end
        S_CALC: begin
          case (r_cmd)
            3'd1: begin
              if (!r_zoom) begin
                r_cx <= CW'(CX0);
                r_cy <= CW'(CY0);
              end
              r_zoom <= 1'b1;
            end
            3'd2: r_zoom <= 1'b0;
            3'd3: if (r_zoom && (r_cx < CW'(IMG_W - HALF))) r_cx <= r_cx + CW'(1);
            3'd4: if (r_zoom && (r_cx > CW'(HALF)))         r_cx <= r_cx - CW'(1);
            3'd5: if (r_zoom && (r_cy > CW'(HALF)))         r_cy <= r_cy - CW'(1);
            3'd6: if (r_zoom && (r_cy < CW'(IMG_H - HALF))) r_cy <= r_cy + CW'(1);
            3'd7: r_mirror <= ~r_mirror;
            default: ;
          endcase
        end
        S_OUT: begin
          r_dout <= r_mem[w_addr];
          if (r_i == IW'(WIN - 1)) begin
            r_i <= '0;
            r_j <= r_j + IW'(1);
          end else begin
            r_i <= r_i + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: default instance (12x9, WIN 4) and a 16x12, WIN 6 instance,
// each checked against a reference view model through an expected-pixel queue.
module tb_lcd_ctrl_param;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] datain;
  logic [2:0] cmd;
  logic       cv_a, cv_b;
  logic [7:0] dout_a, dout_b;
  logic       ov_a, ov_b, bz_a, bz_b, zm_a, zm_b;
  logic [1:0] st_a, st_b;

  always #5 clk = ~clk;

  lcd_ctrl_param u_dut_a (
    .clk(clk), .reset_n(reset_n), .datain(datain), .cmd(cmd), .cmd_valid(cv_a),
    .dataout(dout_a), .output_valid(ov_a), .busy(bz_a), .zoom_mode(zm_a), .dbg_state(st_a)
  );

  lcd_ctrl_param #(
    .IMG_W(16), .IMG_H(12), .WIN(6), .FIT_X0(1), .FIT_SX(2), .FIT_Y0(1), .FIT_SY(2),
    .CX0(8), .CY0(6)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .datain(datain), .cmd(cmd), .cmd_valid(cv_b),
    .dataout(dout_b), .output_valid(ov_b), .busy(bz_b), .zoom_mode(zm_b), .dbg_state(st_b)
  );

  int p_w[2]   = '{12, 16};
  int p_h[2]   = '{9, 12};
  int p_win[2] = '{4, 6};
  int p_fx0[2] = '{1, 1};
  int p_fsx[2] = '{3, 2};
  int p_fy0[2] = '{1, 1};
  int p_fsy[2] = '{2, 2};
  int p_cx0[2] = '{6, 8};
  int p_cy0[2] = '{5, 6};

  int m_zoom[2], m_mir[2], m_cx[2], m_cy[2];
  int beats[2], first_cyc[2];
  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_pix(input int d, input int i, input int j);
    int ip, x, y;
    ip = (m_mir[d] != 0) ? p_win[d] - 1 - i : i;
    if (m_zoom[d] != 0) begin
      x = m_cx[d] - p_win[d] / 2 + ip;
      y = m_cy[d] - p_win[d] / 2 + j;
    end else begin
      x = p_fx0[d] + ip * p_fsx[d];
      y = p_fy0[d] + j * p_fsy[d];
    end
    return 8'(y * p_w[d] + x);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_zoom[d] = 0; m_mir[d] = 0; m_cx[d] = p_cx0[d]; m_cy[d] = p_cy0[d];
    end
  endtask

  // Apply a command to the reference model and queue the view it must produce.
  task automatic model_cmd(input int d, input logic [2:0] c);
    int hw;
    hw = p_win[d] / 2;
    case (c)
      3'd0: begin m_zoom[d] = 0; m_mir[d] = 0; end
      3'd1: begin
        if (m_zoom[d] == 0) begin m_cx[d] = p_cx0[d]; m_cy[d] = p_cy0[d]; end
        m_zoom[d] = 1;
      end
      3'd2: m_zoom[d] = 0;
      3'd3: if (m_zoom[d] != 0 && m_cx[d] < p_w[d] - hw) m_cx[d]++;
      3'd4: if (m_zoom[d] != 0 && m_cx[d] > hw) m_cx[d]--;
      3'd5: if (m_zoom[d] != 0 && m_cy[d] > hw) m_cy[d]--;
      3'd6: if (m_zoom[d] != 0 && m_cy[d] < p_h[d] - hw) m_cy[d]++;
      default: m_mir[d] = 1 - m_mir[d];
    endcase
    for (int j = 0; j < p_win[d]; j++)
      for (int i = 0; i < p_win[d]; i++)
        if (d == 0) exp_q_a.push_back(exp_pix(d, i, j));
        else        exp_q_b.push_back(exp_pix(d, i, j));
  endtask

  task automatic mon(input int d, input logic v, input logic bz, input logic [7:0] data);
    int sz;
    logic [7:0] e;
    if (v) begin
      if (beats[d] == 0) first_cyc[d] = cyc;
      beats[d]++;
      check("busy_during_beat", 32'(bz), 1);
      sz = (d == 0) ? exp_q_a.size() : exp_q_b.size();
      check("exp_q_nonempty", 32'(sz > 0), 1);
      if (sz > 0) begin
        e = (d == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
        check($sformatf("pix_dut%0d", d), 32'(data), 32'(e));
      end
    end
  endtask

  always @(negedge clk) if (reset_n) mon(0, ov_a, bz_a, dout_a);
  always @(negedge clk) if (reset_n) mon(1, ov_b, bz_b, dout_b);

  function automatic logic get_busy(input int d);
    return (d == 0) ? bz_a : bz_b;
  endfunction

  function automatic logic get_valid(input int d);
    return (d == 0) ? ov_a : ov_b;
  endfunction

  task automatic set_cv(input int d, input logic v);
    if (d == 0) cv_a = v; else cv_b = v;
  endtask

  // Issue one command, feed the frame for LOAD, optionally pulse cmd_valid while busy,
  // then check beat count, latency, busy release and zoom_mode.
  task automatic run_cmd(input int d, input logic [2:0] c, input bit poke);
    int acc, n, nload;
    bit done;
    model_cmd(d, c);
    n     = p_win[d] * p_win[d];
    nload = (c == 3'd0) ? p_w[d] * p_h[d] : 0;
    beats[d] = 0; first_cyc[d] = -1; done = 0;
    @(negedge clk);
    cmd = c; set_cv(d, 1'b1);
    @(posedge clk); #1;
    acc = cyc;
    check("busy_after_accept", 32'(get_busy(d)), 1);
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (k == 0) set_cv(d, 1'b0);
      if (k < nload) datain = 8'(k);
      if (poke && k == 3) begin cmd = 3'd0; set_cv(d, 1'b1); end
      if (poke && k == 4) set_cv(d, 1'b0);
      if (beats[d] == n && !get_valid(d)) done = 1;
    end
    check("beat_count", 32'(beats[d]), 32'(n));
    check("busy_released", 32'(get_busy(d)), 0);
    check("first_beat_latency", 32'(first_cyc[d] - acc), 32'((c == 3'd0) ? nload + 1 : 2));
    check("zoom_mode", 32'((d == 0) ? zm_a : zm_b), 32'(m_zoom[d]));
    check("exp_q_drained", 32'((d == 0) ? exp_q_a.size() : exp_q_b.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; datain = '0; cmd = '0; cv_a = 1'b0; cv_b = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_dout_a", 32'(dout_a), 0);
    check("rst_valid_a", 32'(ov_a), 0);
    check("rst_busy_a", 32'(bz_a), 0);
    check("rst_zoom_a", 32'(zm_a), 0);
    check("rst_valid_b", 32'(ov_b), 0);
    check("rst_busy_b", 32'(bz_b), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Default geometry: load, zoom, clamped shifts, mirror, fit-mode shift.
    run_cmd(0, 3'd0, 0);
    run_cmd(0, 3'd1, 0);
    repeat (5) run_cmd(0, 3'd3, 0);
    run_cmd(0, 3'd2, 0);
    run_cmd(0, 3'd1, 0);
    run_cmd(0, 3'd7, 0);
    run_cmd(0, 3'd7, 0);
    run_cmd(0, 3'd2, 0);
    run_cmd(0, 3'd5, 0);
    run_cmd(0, 3'd1, 0);
    repeat (4) run_cmd(0, 3'd5, 0);
    repeat (6) run_cmd(0, 3'd4, 0);
    run_cmd(0, 3'd6, 1);
    repeat (10) run_cmd(0, 3'($urandom_range(1, 7)), 0);

    // Larger geometry with clamps at both horizontal edges and the bottom edge.
    run_cmd(1, 3'd0, 0);
    run_cmd(1, 3'd1, 0);
    repeat (6) run_cmd(1, 3'd3, 0);
    repeat (11) run_cmd(1, 3'd4, 0);
    repeat (4) run_cmd(1, 3'd6, 0);
    run_cmd(1, 3'd7, 0);
    repeat (6) run_cmd(1, 3'($urandom_range(1, 7)), 0);

    // Reset in the middle of an output burst aborts it.
    model_cmd(0, 3'd2);
    @(negedge clk); cmd = 3'd2; cv_a = 1'b1;
    @(negedge clk); cv_a = 1'b0;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_dout", 32'(dout_a), 0);
    check("midrst_valid", 32'(ov_a), 0);
    check("midrst_busy", 32'(bz_a), 0);
    check("midrst_zoom", 32'(zm_a), 0);
    check("midrst_state", 32'(st_a), 0);
    exp_q_a.delete();
    exp_q_b.delete();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    run_cmd(0, 3'd0, 0);
    run_cmd(0, 3'd1, 0);
    run_cmd(0, 3'd4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
